// File: rtl/bet_ledger.sv
// Bankroll ledger for one betting round: captures a wager, holds it in escrow,
// and settles it against the win lights with a saturating 8-bit bankroll.
module bet_ledger #(
    parameter logic [7:0] INIT_BALANCE = 8'd100,
    parameter logic [3:0] TIE_MULT     = 4'd8
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       betenabled,
    input  logic       updatebalanceenable,
    input  logic       player_win,
    input  logic       dealer_win,
    input  logic [9:0] SW,
    output logic [7:0] balance,
    output logic [7:0] stake,
    output logic       bet_valid,
    output logic       broke
);

    typedef enum logic [2:0] {IDLE, BET_OPEN, LOCKED, SETTLE, BROKE} state_t;

    state_t      state_q;
    logic [7:0]  balance_q, stake_q, pend_amt_q;
    logic [1:0]  pend_side_q;
    logic        bet_valid_q, broke_q, pw_q, dw_q;

    logic        accept_d;
    logic [12:0] payout_d, sum_d;
    logic [7:0]  settled_d;

    function automatic logic [7:0] sat8(input logic [12:0] v);
        return (v > 13'd255) ? 8'd255 : v[7:0];
    endfunction

    // Side 01 = player, 10 = banker, 11 = tie; no lights at all voids the hand.
    function automatic logic [12:0] calc_payout(input logic held, input logic [1:0] side,
                                                input logic [7:0] amt, input logic pw,
                                                input logic dw);
        logic [12:0] s;
        s = {5'd0, amt};
        if (!held) return 13'd0;
        if (!pw && !dw) return s;
        case (side)
            2'b11:   return (pw && dw) ? s * ({9'd0, TIE_MULT} + 13'd1) : 13'd0;
            2'b01:   return (pw && dw) ? s : (pw ? (s << 1) : 13'd0);
            2'b10:   return (pw && dw) ? s : (dw ? (s << 1) : 13'd0);
            default: return 13'd0;
        endcase
    endfunction

    always_comb begin
        accept_d  = (pend_amt_q != 8'd0) && (pend_side_q != 2'b00) && (pend_amt_q <= balance_q);
        payout_d  = calc_payout(bet_valid_q, pend_side_q, stake_q, pw_q, dw_q);
        sum_d     = {5'd0, balance_q} + payout_d;
        settled_d = sat8(sum_d);
    end

    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            state_q     <= IDLE;
            balance_q   <= INIT_BALANCE;
            stake_q     <= 8'd0;
            bet_valid_q <= 1'b0;
            broke_q     <= 1'b0;
            pend_amt_q  <= 8'd0;
            pend_side_q <= 2'b00;
            pw_q        <= 1'b0;
            dw_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (betenabled) begin
                        state_q     <= BET_OPEN;
                        pend_amt_q  <= 8'd0;
                        pend_side_q <= 2'b00;
                    end
                end
                BET_OPEN: begin
                    if (betenabled) begin
                        pend_amt_q  <= SW[7:0];
                        pend_side_q <= SW[9:8];
                    end else begin
                        // Lock uses the last captured bet; SW in this cycle is ignored.
                        state_q <= LOCKED;
                        if (accept_d) begin
                            balance_q   <= balance_q - pend_amt_q;
                            stake_q     <= pend_amt_q;
                            bet_valid_q <= 1'b1;
                        end else begin
                            stake_q     <= 8'd0;
                            bet_valid_q <= 1'b0;
                        end
                    end
                end
                LOCKED: begin
                    if (updatebalanceenable) begin
                        state_q <= SETTLE;
                        pw_q    <= player_win;
                        dw_q    <= dealer_win;
                    end
                end
                SETTLE: begin
                    balance_q   <= settled_d;
                    stake_q     <= 8'd0;
                    bet_valid_q <= 1'b0;
                    if (settled_d == 8'd0) begin
                        state_q <= BROKE;
                        broke_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BROKE:   state_q <= BROKE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign balance   = balance_q;
    assign stake     = stake_q;
    assign bet_valid = bet_valid_q;
    assign broke     = broke_q;

endmodule
